// File: rtl/pipe_fixedpointtofloat32.sv
// Pipelined signed fixed-point (WOI.WOF) to IEEE-754 float32 converter, latency WOI+WOF+2.
// Define FXP2FP_ROUND_EN for round-to-nearest (ties away); otherwise the mantissa is truncated.
module pipe_fixedpointtofloat32 #(
  parameter int WOI = 8,
  parameter int WOF = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 in_valid,
  input  logic [WOI+WOF-1:0]   in,
  output logic                 out_valid,
  output logic [31:0]          out
);

  localparam int N = WOI + WOF;
  localparam logic [N-1:0] ONE  = N'(1);
  localparam logic [8:0]   EXP0 = 9'(127 + WOI - 1);

  // Handshake: in_valid qualifies in on the same edge; there is no ready, the
  // pipeline advances every cycle and out_valid qualifies out N+2 edges later.

  // Index 0 is the abs stage, index i (1..N-1) is the output of normalize stage i.
  logic           sign_q [N];
  logic [N-1:0]   mag_q  [N];
  logic [8:0]     exp_q  [N];
  logic [N:0]     vld_q;
  logic [31:0]    res_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < N; i++) begin
        sign_q[i] <= 1'b0;
        mag_q[i]  <= '0;
        exp_q[i]  <= '0;
      end
    end else begin
      sign_q[0] <= in[N-1];
      mag_q[0]  <= in[N-1] ? (~in + ONE) : in;
      exp_q[0]  <= EXP0;
      for (int i = 1; i < N; i++) begin
        sign_q[i] <= sign_q[i-1];
        if (mag_q[i-1] != '0 && !mag_q[i-1][N-1]) begin
          mag_q[i] <= mag_q[i-1] << 1;
          exp_q[i] <= exp_q[i-1] - 9'd1;
        end else begin
          mag_q[i] <= mag_q[i-1];
          exp_q[i] <= exp_q[i-1];
        end
      end
    end
  end

  // Mantissa sits just below the (now implicit) leading one.
  logic [22:0] man_t;
  generate
    if (N >= 24) begin : g_man_wide
      assign man_t = mag_q[N-1][N-2 -: 23];
    end else begin : g_man_narrow
      assign man_t = {mag_q[N-1][N-2:0], {(24-N){1'b0}}};
    end
  endgenerate

  logic [22:0] man_f;
  logic [7:0]  exp_f;

`ifdef FXP2FP_ROUND_EN
  logic        rnd;
  logic [23:0] man_sum;
  generate
    if (N >= 25) begin : g_rnd_bit
      assign rnd = mag_q[N-1][N-25];
    end else begin : g_rnd_none
      assign rnd = 1'b0;
    end
  endgenerate

  // A carry out of the mantissa means the magnitude rounded up to the next power of two.
  always_comb begin
    man_sum = {1'b0, man_t} + {23'b0, rnd};
    man_f   = man_sum[23] ? 23'd0 : man_sum[22:0];
    exp_f   = exp_q[N-1][7:0] + {7'b0, man_sum[23]};
  end
`else
  always_comb begin
    man_f = man_t;
    exp_f = exp_q[N-1][7:0];
  end
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      res_q     <= '0;
      out       <= '0;
      vld_q     <= '0;
      out_valid <= 1'b0;
    end else begin
      res_q     <= (mag_q[N-1] == '0) ? 32'h0 : {sign_q[N-1], exp_f, man_f};
      out       <= res_q;
      vld_q     <= {vld_q[N-1:0], in_valid};
      out_valid <= vld_q[N];
    end
  end

endmodule

// File: tb/tb_pipe_fixedpointtofloat32.sv
// Bench for pipe_fixedpointtofloat32: four parameterisations driven in parallel against an
// arithmetic reference conversion, plus directed latency, boundary, streaming and reset cases.
module tb_pipe_fixedpointtofloat32;

  localparam int NDUT = 4;

`ifdef FXP2FP_ROUND_EN
  localparam logic [31:0] EXP_7FFF_16_16 = 32'h47000000;
`else
  localparam logic [31:0] EXP_7FFF_16_16 = 32'h46FFFFFF;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] din  [NDUT];
  logic        vin  [NDUT];
  logic [31:0] dout [NDUT];
  logic        vout [NDUT];

  int woi_a [NDUT] = '{8, 1, 16, 32};
  int wof_a [NDUT] = '{8, 31, 16, 0};
  int dep   [NDUT] = '{18, 34, 34, 34};

  pipe_fixedpointtofloat32 #(.WOI(8), .WOF(8)) u_dut_8_8 (
    .clk(clk), .rstn(rstn), .in_valid(vin[0]), .in(din[0][15:0]),
    .out_valid(vout[0]), .out(dout[0]));
  pipe_fixedpointtofloat32 #(.WOI(1), .WOF(31)) u_dut_1_31 (
    .clk(clk), .rstn(rstn), .in_valid(vin[1]), .in(din[1]),
    .out_valid(vout[1]), .out(dout[1]));
  pipe_fixedpointtofloat32 #(.WOI(16), .WOF(16)) u_dut_16_16 (
    .clk(clk), .rstn(rstn), .in_valid(vin[2]), .in(din[2]),
    .out_valid(vout[2]), .out(dout[2]));
  pipe_fixedpointtofloat32 #(.WOI(32), .WOF(0)) u_dut_32_0 (
    .clk(clk), .rstn(rstn), .in_valid(vin[3]), .in(din[3]),
    .out_valid(vout[3]), .out(dout[3]));

  // scoreboard: per-DUT delay line of {valid, expected word}, one slot per cycle
  logic [32:0] exp_q [NDUT][34];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mask_n(input int n);
    logic [32:0] one_hot;
    one_hot = 33'd1 << n;
    return 32'(one_hot - 33'd1);
  endfunction

  function automatic logic [63:0] to_s64(input int n, input logic [31:0] raw);
    logic [63:0] r;
    r = {32'b0, raw & mask_n(n)};
    if (raw[n-1]) r = r | ~((64'd1 << n) - 64'd1);
    return r;
  endfunction

  // Reference: value = x / 2^wof, float exponent from the leading one, 24 significant bits kept.
  function automatic logic [31:0] ref_conv(input int wof, input logic [63:0] x);
    logic        s;
    logic [63:0] m;
    int          p;
    int          e;
    logic [24:0] q;
    logic        r;
    s = x[63];
    m = s ? (~x + 64'd1) : x;
    if (m == 64'd0) return 32'h0;
    p = 63;
    while (!m[p]) p--;
    e = p - wof + 127;
    r = 1'b0;
    if (p > 23) begin
      q = 25'(m >> (p - 23));
      r = m[p-24];
    end else begin
      q = 25'(m << (23 - p));
    end
`ifdef FXP2FP_ROUND_EN
    if (r) q = q + 25'd1;
    if (q[24]) begin
      q = q >> 1;
      e++;
    end
`endif
    return {s, 8'(e), q[22:0]};
  endfunction

  task automatic reset_models();
    for (int d = 0; d < NDUT; d++)
      for (int j = 0; j < 34; j++) exp_q[d][j] = '0;
  endtask

  // One cycle: sample inputs into the model at the rising edge, check outputs at the falling edge.
  task automatic step();
    int n;
    @(posedge clk);
    if (!rstn) begin
      reset_models();
    end else begin
      for (int d = 0; d < NDUT; d++) begin
        n = woi_a[d] + wof_a[d];
        for (int j = 0; j < dep[d] - 1; j++) exp_q[d][j] = exp_q[d][j+1];
        exp_q[d][dep[d]-1] = {vin[d], ref_conv(wof_a[d], to_s64(n, din[d]))};
      end
    end
    @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      check_eq($sformatf("valid_%0d", d), {31'b0, vout[d]}, {31'b0, exp_q[d][0][32]});
      if (exp_q[d][0][32])
        check_eq($sformatf("data_%0d", d), dout[d], exp_q[d][0][31:0]);
    end
  endtask

  // driver: one valid sample into the 8.8 instance, wait for it, check latency and value
  task automatic send8(input logic [15:0] v, input logic [31:0] expv, input string tag);
    int cnt;
    vin[0] = 1'b1;
    din[0] = {16'b0, v};
    step();
    vin[0] = 1'b0;
    cnt = 1;
    while (!vout[0] && cnt < 40) begin
      step();
      cnt++;
    end
    check_eq({tag, "_lat"}, 32'(cnt), 32'd18);
    check_eq(tag, dout[0], expv);
  endtask

  logic        sv [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
  logic [15:0] sd [5] = '{16'h0100, 16'h0200, 16'h0300, 16'h0000, 16'hFE00};
  logic [31:0] se [5] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h0, 32'hC0000000};

  initial begin
    int cnt;
    int n;
    logic [31:0] msk;
    for (int d = 0; d < NDUT; d++) begin
      vin[d] = 1'b0;
      din[d] = '0;
    end
    reset_models();
    #1;
    for (int d = 0; d < NDUT; d++) begin
      check_eq($sformatf("rst_valid_%0d", d), {31'b0, vout[d]}, 32'd0);
      check_eq($sformatf("rst_data_%0d", d), dout[d], 32'h0);
    end
    step();
    step();
    rstn = 1'b1;

    // directed 8.8 values and boundaries
    send8(16'h0100, 32'h3F800000, "one");
    send8(16'hFF00, 32'hBF800000, "minus_one");
    send8(16'h8000, 32'hC3000000, "most_neg");
    send8(16'h0001, 32'h3B800000, "lsb");
    send8(16'h7FFF, 32'h42FFFE00, "max_pos");
    send8(16'h0000, 32'h00000000, "zero");

    // 16.16 all-ones magnitude: mantissa carry when rounding
    vin[2] = 1'b1;
    din[2] = 32'h7FFFFFFF;
    step();
    vin[2] = 1'b0;
    cnt = 1;
    while (!vout[2] && cnt < 60) begin
      step();
      cnt++;
    end
    check_eq("w16_lat", 32'(cnt), 32'd34);
    check_eq("w16_max", dout[2], EXP_7FFF_16_16);

    // streaming with a one-cycle gap
    for (int i = 0; i < 23; i++) begin
      if (i < 5) begin
        vin[0] = sv[i];
        din[0] = {16'b0, sd[i]};
      end else begin
        vin[0] = 1'b0;
      end
      step();
      if (i >= 17) begin
        check_eq("stream_v", {31'b0, vout[0]}, {31'b0, sv[i-17]});
        if (sv[i-17]) check_eq("stream_d", dout[0], se[i-17]);
      end
    end

    // asynchronous reset while samples are in flight and emerging
    for (int i = 0; i < 20; i++) begin
      vin[0] = 1'b1;
      din[0] = {16'b0, 16'($urandom)};
      step();
    end
    rstn = 1'b0;
    vin[0] = 1'b0;
    #1;
    check_eq("async_rst_valid", {31'b0, vout[0]}, 32'd0);
    check_eq("async_rst_data", dout[0], 32'h0);
    reset_models();
    step();
    rstn = 1'b1;
    for (int i = 0; i < 25; i++) step();
    send8(16'h0300, 32'h40400000, "post_rst");

    // randomized stimulus on all instances
    for (int c = 0; c < 10000; c++) begin
      for (int d = 0; d < NDUT; d++) begin
        n = woi_a[d] + wof_a[d];
        msk = mask_n(n);
        vin[d] = ($urandom_range(0, 9) != 0);
        case ($urandom_range(0, 15))
          0:       din[d] = 32'h0;
          1:       din[d] = 32'h1 << (n - 1);
          2:       din[d] = msk >> 1;
          3:       din[d] = msk;
          4:       din[d] = 32'h1;
          default: din[d] = $urandom & msk;
        endcase
      end
      step();
    end
    for (int d = 0; d < NDUT; d++) vin[d] = 1'b0;
    for (int i = 0; i < 40; i++) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
